nx_credit_arbiter: RTL and testbench

Shares one downstream credit pool between `N_REQ` requesters. Each cycle it grants at most one eligible requester in round-robin order, and each grant consumes one credit. It tracks outstanding credits both pool-wide and per requester, and enforces a software pool limit and a software per-requester limit. It sits between the engine front-end request ports and a shared downstream resource that returns credits tagged with the originating requester id. It also provides a software-driven drain sequence for quiescing before reconfiguration.

---
 rtl/nx_credit_arb_pkg.sv | 32 +++
 rtl/nx_rr_pick.sv | 32 +++
 rtl/nx_credit_arbiter.sv | 125 ++++++++++++
 tb/tb_nx_credit_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nx_credit_arb_pkg.sv
// rtl/nx_credit_arb_pkg.sv - shared types and helpers for the credit arbiter
package nx_credit_arb_pkg;

   localparam int CNT_W  = 16;
   localparam int MASK_W = 16;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      DRAIN   = 2'd1,
      DRAINED = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic [CNT_W-1:0]  credit_limit;
      logic [CNT_W-1:0]  req_limit;
      logic [MASK_W-1:0] req_mask;
      logic              drain;
   } arb_sw_config_t;

   typedef struct packed {
      logic             drained;
      logic [CNT_W-1:0] pool_outstanding;
      logic             return_err;
      logic             limit_err;
   } arb_hw_status_t;

   // Width needed to index or count up to n-1; never narrower than one bit.
   function automatic int log_vec(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/nx_rr_pick.sv
// rtl/nx_rr_pick.sv - combinational round-robin picker starting at a pointer
module nx_rr_pick
   import nx_credit_arb_pkg::*;
#(
   parameter int N  = 4,
   localparam int IW = log_vec(N)
) (
   input  logic [N-1:0]  elig,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   logic          found;
   logic [IW-1:0] j;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = '0;
      for (int k = 0; k < N; k++) begin
         j = IW'((int'(ptr) + k) % N);
         if (!found && elig[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = j;
         end
      end
   end

endmodule

// File: rtl/nx_credit_arbiter.sv
// rtl/nx_credit_arbiter.sv - shared credit pool arbiter with per-requester limits and drain
module nx_credit_arbiter
   import nx_credit_arb_pkg::*;
#(
   parameter int N_REQ         = 4,
   parameter int N_MAX_CREDITS = 16,
   parameter int N_MAX_PER_REQ = 8,
   localparam int IW = log_vec(N_REQ),
   localparam int PW = log_vec(N_MAX_CREDITS + 1),
   localparam int OW = log_vec(N_MAX_PER_REQ + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sw_init,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IW-1:0]    gnt_id,
   input  logic             credit_return,
   input  logic [IW-1:0]    credit_return_id,
   input  logic [PW-1:0]    sw_credit_limit,
   input  logic [OW-1:0]    sw_req_limit,
   input  logic [N_REQ-1:0] sw_req_mask,
   input  logic             sw_drain,
   output logic             drained,
   output logic [PW-1:0]    pool_outstanding,
   output logic             return_err,
   output logic             limit_err
);

   arb_state_e     state_r, state_n;
   arb_hw_status_t status_r, status_n;

   logic [OW-1:0]    own_r [N_REQ];
   logic [OW-1:0]    own_v [N_REQ];
   logic [OW-1:0]    own_n [N_REQ];
   logic [IW-1:0]    rr_ptr_r, rr_ptr_n;
   logic [CNT_W-1:0] pool_v;
   logic [PW-1:0]    eff_credit;
   logic [OW-1:0]    eff_req;
   logic             clear, ret_bad, ret_take, over_limit, any_gnt;
   logic [N_REQ-1:0] elig, pick_gnt;
   logic [IW-1:0]    pick_idx;

   assign clear      = rst | sw_init;
   assign eff_credit = (int'(sw_credit_limit) > N_MAX_CREDITS) ? PW'(N_MAX_CREDITS) : sw_credit_limit;
   assign eff_req    = (int'(sw_req_limit) > N_MAX_PER_REQ) ? OW'(N_MAX_PER_REQ) : sw_req_limit;
   assign over_limit = (int'(sw_credit_limit) > N_MAX_CREDITS) | (int'(sw_req_limit) > N_MAX_PER_REQ);

   // A return against an empty owner or empty pool is an error and is dropped.
   assign ret_bad  = credit_return & ((own_r[credit_return_id] == '0) |
                                      (status_r.pool_outstanding == '0));
   assign ret_take = credit_return & ~ret_bad;
   assign pool_v   = status_r.pool_outstanding - CNT_W'(ret_take);

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         own_v[i] = own_r[i] - OW'(ret_take && (credit_return_id == IW'(i)));
         elig[i]  = req[i] & sw_req_mask[i] & ~clear & (state_r == RUN) &
                    (own_v[i] < eff_req) & (pool_v < CNT_W'(eff_credit));
      end
   end

   nx_rr_pick #(.N(N_REQ)) u_pick (
      .elig (elig),
      .ptr  (rr_ptr_r),
      .gnt  (pick_gnt),
      .idx  (pick_idx)
   );

   assign gnt     = pick_gnt;
   assign gnt_id  = pick_idx;
   assign any_gnt = |pick_gnt;

   always_comb begin
      state_n = state_r;
      unique case (state_r)
         RUN:     if (sw_drain) state_n = DRAIN;
         DRAIN: begin
            if (!sw_drain)           state_n = RUN;
            else if (pool_v == '0)   state_n = DRAINED;
         end
         DRAINED: if (!sw_drain) state_n = RUN;
         default: state_n = RUN;
      endcase
   end

   always_comb begin
      rr_ptr_n = rr_ptr_r;
      if (any_gnt) begin
         rr_ptr_n = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
      end
      for (int i = 0; i < N_REQ; i++) begin
         own_n[i] = own_v[i] + OW'(pick_gnt[i]);
      end
      status_n                  = status_r;
      status_n.pool_outstanding = pool_v + CNT_W'(any_gnt);
      status_n.drained          = (state_n == DRAINED);
      status_n.return_err       = status_r.return_err | ret_bad;
      status_n.limit_err        = status_r.limit_err | over_limit;
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_r  <= RUN;
         status_r <= '0;
         rr_ptr_r <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            own_r[i] <= '0;
         end
      end else begin
         state_r  <= state_n;
         status_r <= status_n;
         rr_ptr_r <= rr_ptr_n;
         for (int i = 0; i < N_REQ; i++) begin
            own_r[i] <= own_n[i];
         end
      end
   end

   assign drained          = status_r.drained;
   assign pool_outstanding = status_r.pool_outstanding[PW-1:0];
   assign return_err       = status_r.return_err;
   assign limit_err        = status_r.limit_err;

endmodule

// File: tb/tb_nx_credit_arbiter.sv
// tb/tb_nx_credit_arbiter.sv - self-checking bench for nx_credit_arbiter
module tb_nx_credit_arbiter;

   localparam int N   = 4;
   localparam int NMC = 16;
   localparam int NMP = 8;

   logic       clk = 1'b0;
   logic       rst, sw_init, credit_return, sw_drain;
   logic [3:0] req, sw_req_mask, gnt, sw_req_limit;
   logic [1:0] gnt_id, credit_return_id;
   logic [4:0] sw_credit_limit, pool_outstanding;
   logic       drained, return_err, limit_err;

   always #5 clk = ~clk;

   nx_credit_arbiter #(.N_REQ(N), .N_MAX_CREDITS(NMC), .N_MAX_PER_REQ(NMP)) dut (
      .clk              (clk),
      .rst              (rst),
      .sw_init          (sw_init),
      .req              (req),
      .gnt              (gnt),
      .gnt_id           (gnt_id),
      .credit_return    (credit_return),
      .credit_return_id (credit_return_id),
      .sw_credit_limit  (sw_credit_limit),
      .sw_req_limit     (sw_req_limit),
      .sw_req_mask      (sw_req_mask),
      .sw_drain         (sw_drain),
      .drained          (drained),
      .pool_outstanding (pool_outstanding),
      .return_err       (return_err),
      .limit_err        (limit_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: counters as integers, state 0=run 1=drain 2=drained.
   int   m_pool = 0, m_rr = 0, m_state = 0;
   int   m_own [N] = '{0, 0, 0, 0};
   bit   m_rerr = 0, m_lerr = 0, m_drained = 0;
   int   n_pool, n_rr, n_state;
   int   n_own [N];
   bit   n_rerr, n_lerr;
   logic [3:0] e_gnt;
   logic [1:0] e_id;

   function automatic void model_eval();
      int  id, pv, cl, rl, g, i;
      int  ov [N];
      bit  bad, take;
      id   = int'(credit_return_id);
      bad  = credit_return && (m_own[id] == 0 || m_pool == 0);
      take = credit_return && !bad;
      pv   = m_pool - (take ? 1 : 0);
      for (int k = 0; k < N; k++) ov[k] = m_own[k] - ((take && id == k) ? 1 : 0);
      cl = (int'(sw_credit_limit) > NMC) ? NMC : int'(sw_credit_limit);
      rl = (int'(sw_req_limit) > NMP) ? NMP : int'(sw_req_limit);
      g  = -1;
      if (!(rst || sw_init) && m_state == 0) begin
         for (int k = 0; k < N; k++) begin
            i = (m_rr + k) % N;
            if (g < 0 && req[i] && sw_req_mask[i] && ov[i] < rl && pv < cl) g = i;
         end
      end
      e_gnt = '0;
      e_id  = '0;
      if (g >= 0) begin
         e_gnt[g] = 1'b1;
         e_id     = 2'(g);
      end
      if (rst || sw_init) begin
         n_pool = 0; n_rr = 0; n_state = 0; n_rerr = 0; n_lerr = 0;
         for (int k = 0; k < N; k++) n_own[k] = 0;
      end else begin
         n_pool = pv + ((g >= 0) ? 1 : 0);
         for (int k = 0; k < N; k++) n_own[k] = ov[k] + ((g == k) ? 1 : 0);
         n_rr   = (g >= 0) ? (g + 1) % N : m_rr;
         n_rerr = m_rerr || bad;
         n_lerr = m_lerr || int'(sw_credit_limit) > NMC || int'(sw_req_limit) > NMP;
         n_state = m_state;
         case (m_state)
            0: if (sw_drain) n_state = 1;
            1: if (!sw_drain) n_state = 0; else if (pv == 0) n_state = 2;
            default: if (!sw_drain) n_state = 0;
         endcase
      end
   endfunction

   task automatic tick();
      model_eval();
      @(posedge clk);
      m_pool = n_pool; m_rr = n_rr; m_state = n_state;
      m_rerr = n_rerr; m_lerr = n_lerr; m_drained = (n_state == 2);
      for (int k = 0; k < N; k++) m_own[k] = n_own[k];
      #1;
   endtask

   task automatic set_idle();
      rst = 0; sw_init = 0; req = '0; credit_return = 0; credit_return_id = '0;
      sw_credit_limit = 5'd16; sw_req_limit = 4'd8; sw_req_mask = 4'hf; sw_drain = 0;
   endtask

   task automatic do_init();
      set_idle();
      sw_init = 1;
      tick();
      sw_init = 0;
   endtask

   task automatic test_reset();
      set_idle();
      rst = 1;
      #1;
      n_tests++;
      if (gnt !== 4'b0) begin n_fail++; $display("FAIL reset_gnt_during: got %b want 0000", gnt); end
      tick();
      rst = 0;
      #1;
      n_tests++;
      if ({gnt, gnt_id} !== 6'b0) begin n_fail++; $display("FAIL reset_gnt: got %b/%0d want 0/0", gnt, gnt_id); end
      n_tests++;
      if ({drained, pool_outstanding, return_err, limit_err} !== 8'b0) begin
         n_fail++;
         $display("FAIL reset_regs: drained=%b pool=%0d rerr=%b lerr=%b want all 0", drained, pool_outstanding, return_err, limit_err);
      end
   endtask

   task automatic test_fill();
      logic [3:0] want;
      req = 4'hf;
      for (int c = 0; c < 17; c++) begin
         #1;
         want = '0;
         if (c < 16) want[c % 4] = 1'b1;
         n_tests++;
         if (gnt !== want || (c < 16 && gnt_id !== 2'(c % 4))) begin
            n_fail++;
            $display("FAIL fill_gnt cyc %0d: got %b/%0d want %b/%0d", c, gnt, gnt_id, want, c % 4);
         end
         tick();
      end
      req = '0;
      n_tests++;
      if (pool_outstanding !== 5'd16) begin n_fail++; $display("FAIL fill_pool: got %0d want 16", pool_outstanding); end
   endtask

   task automatic test_return_full();
      credit_return = 1; credit_return_id = 2'd2; req = 4'b0100;
      #1;
      n_tests++;
      if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin n_fail++; $display("FAIL full_return_gnt: got %b/%0d want 0100/2", gnt, gnt_id); end
      tick();
      credit_return = 0; req = '0;
      n_tests++;
      if (pool_outstanding !== 5'd16) begin n_fail++; $display("FAIL full_return_pool: got %0d want 16", pool_outstanding); end
   endtask

   task automatic test_req_limit();
      int cnt = 0;
      do_init();
      sw_req_limit = 4'd2; req = 4'b0010;
      for (int c = 0; c < 5; c++) begin
         #1;
         model_eval();
         n_tests++;
         if (gnt !== e_gnt) begin n_fail++; $display("FAIL req_limit_gnt cyc %0d: got %b want %b", c, gnt, e_gnt); end
         if (gnt[1]) cnt++;
         tick();
      end
      n_tests++;
      if (cnt != 2) begin n_fail++; $display("FAIL req_limit_count: got %0d want 2", cnt); end
      credit_return = 1; credit_return_id = 2'd1;
      #1;
      n_tests++;
      if (gnt !== 4'b0010) begin n_fail++; $display("FAIL req_limit_regrant: got %b want 0010", gnt); end
      tick();
      credit_return = 0; req = '0;
      n_tests++;
      if (pool_outstanding !== 5'd2) begin n_fail++; $display("FAIL req_limit_pool: got %0d want 2", pool_outstanding); end
      sw_req_limit = 4'd8;
   endtask

   task automatic test_return_err();
      do_init();
      credit_return = 1; credit_return_id = 2'd3;
      tick();
      credit_return = 0;
      n_tests++;
      if (return_err !== 1'b1 || pool_outstanding !== 5'd0) begin
         n_fail++; $display("FAIL return_err_set: got err=%b pool=%0d want 1/0", return_err, pool_outstanding);
      end
      repeat (3) tick();
      n_tests++;
      if (return_err !== 1'b1) begin n_fail++; $display("FAIL return_err_sticky: got %b want 1", return_err); end
      do_init();
      n_tests++;
      if (return_err !== 1'b0) begin n_fail++; $display("FAIL return_err_clear: got %b want 0", return_err); end
   endtask

   task automatic test_drain();
      logic [1:0] ids [5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
      do_init();
      req = 4'hf;
      repeat (5) tick();
      req = '0;
      sw_drain = 1;
      tick();
      req = 4'hf;
      for (int k = 0; k < 5; k++) begin
         credit_return = 1; credit_return_id = ids[k];
         #1;
         n_tests++;
         if (gnt !== 4'b0) begin n_fail++; $display("FAIL drain_gnt ret %0d: got %b want 0000", k, gnt); end
         tick();
         n_tests++;
         if (drained !== (k == 4)) begin n_fail++; $display("FAIL drain_flag ret %0d: got %b want %b", k, drained, k == 4); end
      end
      credit_return = 0; sw_drain = 0;
      #1;
      n_tests++;
      if (gnt !== 4'b0) begin n_fail++; $display("FAIL drained_exit_gnt: got %b want 0000", gnt); end
      tick();
      #1;
      n_tests++;
      if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin n_fail++; $display("FAIL drain_resume: got %b/%0d want 0010/1", gnt, gnt_id); end
      tick();
      req = '0;
      n_tests++;
      if (drained !== 1'b0 || pool_outstanding !== 5'd1) begin
         n_fail++; $display("FAIL drain_after: got drained=%b pool=%0d want 0/1", drained, pool_outstanding);
      end
   endtask

   task automatic test_rst_mid();
      do_init();
      req = 4'hf;
      repeat (7) tick();
      rst = 1;
      #1;
      n_tests++;
      if (gnt !== 4'b0 || gnt_id !== 2'd0) begin n_fail++; $display("FAIL rst_mid_gnt: got %b/%0d want 0/0", gnt, gnt_id); end
      tick();
      rst = 0;
      n_tests++;
      if ({drained, pool_outstanding, return_err, limit_err} !== 8'b0) begin
         n_fail++; $display("FAIL rst_mid_regs: drained=%b pool=%0d rerr=%b lerr=%b want 0", drained, pool_outstanding, return_err, limit_err);
      end
      #1;
      n_tests++;
      if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rst_mid_first: got %b want 0001", gnt); end
      tick();
      req = '0; credit_return = 1; credit_return_id = 2'd2;
      tick();
      credit_return = 0;
      n_tests++;
      if (return_err !== 1'b1) begin n_fail++; $display("FAIL rst_mid_inflight: got %b want 1", return_err); end
   endtask

   task automatic test_limit_clamp();
      do_init();
      sw_credit_limit = 5'd31; req = 4'hf;
      repeat (17) tick();
      n_tests++;
      if (pool_outstanding !== 5'd16 || limit_err !== 1'b1) begin
         n_fail++; $display("FAIL clamp: got pool=%0d lerr=%b want 16/1", pool_outstanding, limit_err);
      end
      sw_credit_limit = 5'd4;
      #1;
      n_tests++;
      if (gnt !== 4'b0) begin n_fail++; $display("FAIL lowered_limit_gnt: got %b want 0000", gnt); end
      tick();
      do_init();
      n_tests++;
      if (limit_err !== 1'b0) begin n_fail++; $display("FAIL clamp_clear: got %b want 0", limit_err); end
   endtask

   task automatic test_random();
      do_init();
      for (int c = 0; c < 1500; c++) begin
         req              = 4'($urandom);
         sw_req_mask      = ($urandom_range(7, 0) == 0) ? 4'($urandom) : 4'hf;
         credit_return    = ($urandom_range(2, 0) == 0);
         credit_return_id = 2'($urandom);
         sw_credit_limit  = ($urandom_range(49, 0) == 0) ? 5'($urandom_range(31, 17)) : 5'($urandom_range(16, 1));
         sw_req_limit     = ($urandom_range(49, 0) == 0) ? 4'($urandom_range(15, 9)) : 4'($urandom_range(8, 1));
         if ($urandom_range(39, 0) == 0) sw_drain = ~sw_drain;
         sw_init          = ($urandom_range(149, 0) == 0);
         rst              = ($urandom_range(299, 0) == 0);
         #1;
         model_eval();
         n_tests++;
         if (gnt !== e_gnt || gnt_id !== e_id) begin
            n_fail++; $display("FAIL rand_gnt cyc %0d: got %b/%0d want %b/%0d", c, gnt, gnt_id, e_gnt, e_id);
         end
         tick();
         n_tests++;
         if (pool_outstanding !== 5'(m_pool) || drained !== m_drained ||
             return_err !== m_rerr || limit_err !== m_lerr) begin
            n_fail++;
            $display("FAIL rand_regs cyc %0d: got pool=%0d dr=%b rerr=%b lerr=%b want %0d/%b/%b/%b",
                     c, pool_outstanding, drained, return_err, limit_err, m_pool, m_drained, m_rerr, m_lerr);
         end
      end
      set_idle();
   endtask

   initial begin
      test_reset();
      test_fill();
      test_return_full();
      test_req_limit();
      test_return_err();
      test_drain();
      test_rst_mid();
      test_limit_clamp();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
